wb_port_arbiter: RTL
====================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback path and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and merged into idle write-port slots. Under backlog, the arbiter stalls the pipeline to drain them. It sits between the writeback cycle and the register file and drives the registered write-enable, write-address and write-data.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a queued MDU result may wait before it forces a drain
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline writeback request (RegWrite of writeback stage)
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline result
- pipe_stall  out  1  pipeline must freeze; pipe_* held stable while high
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; transfer when mdu_valid && mdu_ready
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)

## Operation
- FIFO entry = {live, addr, data}. Enqueue on MDU handshake with live=1.
- FSM states:
  - EMPTY: FIFO empty. Pipeline always granted.
  - PENDING: FIFO non-empty, pipeline priority. Head granted only when pipe_valid=0.
  - FORCED: head granted unconditionally. pipe_stall=1.
- Transitions:
  - EMPTY→PENDING on enqueue.
  - PENDING→FORCED when starve_cnt==STARVE_MAX or FIFO full.
  - PENDING/FORCED→EMPTY when a dequeue leaves the FIFO empty with no simultaneous enqueue.
  - FORCED→PENDING after one dequeue if the FIFO is still non-empty and not full.
- pipe_stall is combinational, = (state==FORCED) && pipe_valid. A stalled pipeline request is not written that cycle.
- starve_cnt:
  - increments each cycle in PENDING when the head is not granted
  - clears on any dequeue, and on entering EMPTY
  - saturates at STARVE_MAX
- mdu_ready = !full, registered from occupancy. No enqueue when full, even if a dequeue occurs that cycle.
- Enqueue and dequeue in the same cycle are permitted when not full; occupancy is unchanged.
- WAW kill: a granted pipeline write clears `live` on every queued entry with a matching addr.
  - Pipeline writebacks are always younger than outstanding MDU results; the hazard unit guarantees this.
  - A killed entry still dequeues normally but produces rf_we=0.
  - An MDU enqueue in the same cycle as a matching pipeline grant is not killed, because it is younger.
- Address 0: any grant with addr==0 produces rf_we=0 and still consumes the slot.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is a separate counter of width clog2(FIFO_DEPTH)+1.

## Timing
- Grant decision is combinational. rf_we/rf_waddr/rf_wdata are registered: write appears 1 cycle after grant.
- MDU result latency in an idle system: handshake cycle N → dequeue N+1 → rf_we at N+2.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - FIFO empty, all live=0, state EMPTY, starve_cnt=0
  - mdu_ready=0 while rst is high, 1 from the first cycle after
  - pipe_stall=0
- Reset mid-operation discards all queued MDU results. The MDU is reset by the same rst.
- Worst-case pipeline stall per forced drain: 1 cycle per entry drained in FORCED.

## Structure
- Package wb_arb_pkg:
  - state enum {EMPTY, PENDING, FORCED}
  - REG_ZERO address constant
  - default DATA_W/ADDR_W localparams
- Sub-module wb_result_fifo:
  - parameterised storage, pointers and occupancy
  - per-entry live bits with an address-match kill port
  - full/empty outputs
- Arbiter FSM, starve counter and output registers live in the top module.

## Test plan
- Idle MDU: pipe_valid=1, addr=5, data=0x11 → rf_we=1, rf_waddr=5, rf_wdata=0x11 next cycle; pipe_stall never asserted.
- Gap fill: MDU addr=7, data=0xAA at cycle 0, pipe_valid=0 → rf_we=1, waddr=7, wdata=0xAA at cycle 2; mdu_ready stays 1.
- Starvation: pipe_valid held 1, one MDU result queued → after 4 ungranted cycles state FORCED, pipe_stall=1 for one cycle, MDU result written, pipeline write follows next cycle.
- Full FIFO: two MDU results enqueued under continuous pipe_valid → mdu_ready=0, FORCED, both drained in order, mdu_ready returns to 1.
- WAW kill: MDU result addr=9 queued, pipeline writes addr=9 data=0x55 → rf shows 0x55; later dequeue of the killed entry gives rf_we=0.
- Reset mid-drain with 2 entries queued → next cycle rf_we=0, mdu_ready=0; after reset, first pipeline write passes unstalled.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Writes to this register are dropped but still consume the port slot.
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_FORCED  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small in-order buffer of MDU results, with a per-entry live bit that a
// younger pipeline write to the same register can clear.
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              head_live,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic              empty_next,
    output logic              full_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (addr_q[i] == kill_addr)) begin
                live_d[i] = 1'b0;
            end
        end
        if (deq) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        // The incoming entry is younger than any same-cycle pipeline write.
        if (enq) begin
            live_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q] = enq_addr;
            data_d[wr_ptr_q] = enq_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign head_live  = live_q[rd_ptr_q];
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty_next = (count_d == '0);
    assign full_next  = (count_d == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback and
// buffered MDU results; MDU results fill idle slots or force a short stall.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output arb_state_e        dbg_state
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(REG_ZERO);

    arb_state_e        state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d, starve_sat;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              mdu_ready_q, mdu_ready_d;

    logic              enq, deq, grant_pipe;
    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fifo_empty, fifo_full, fifo_empty_next, fifo_full_next;

    assign enq = mdu_valid && mdu_ready_q;

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .enq_addr   (mdu_addr),
        .enq_data   (mdu_data),
        .deq        (deq),
        .kill_en    (grant_pipe),
        .kill_addr  (pipe_addr),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .empty_next (fifo_empty_next),
        .full_next  (fifo_full_next)
    );

    // Grant decision depends only on the registered state and the pipeline request.
    always_comb begin
        grant_pipe = 1'b0;
        deq        = 1'b0;
        pipe_stall = 1'b0;
        case (state_q)
            ST_EMPTY:   grant_pipe = pipe_valid;
            ST_PENDING: begin
                grant_pipe = pipe_valid;
                deq        = !pipe_valid && !fifo_empty;
            end
            ST_FORCED: begin
                deq        = 1'b1;
                pipe_stall = pipe_valid;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        starve_sat = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + SC_W'(1);
        case (state_q)
            ST_EMPTY: begin
                if (enq) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (deq) begin
                    if (fifo_empty_next) state_d = ST_EMPTY;
                end else if ((starve_sat == STARVE_LIM) || fifo_full) begin
                    state_d = ST_FORCED;
                end
            end
            ST_FORCED: begin
                if (fifo_empty_next)     state_d = ST_EMPTY;
                else if (!fifo_full_next) state_d = ST_PENDING;
            end
            default: state_d = ST_EMPTY;
        endcase

        starve_d = (state_q == ST_PENDING && !deq) ? starve_sat : '0;

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_pipe) begin
            rf_we_d    = (pipe_addr != ZERO_ADDR);
            rf_waddr_d = pipe_addr;
            rf_wdata_d = pipe_data;
        end else if (deq) begin
            rf_we_d    = head_live && (head_addr != ZERO_ADDR);
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end

        mdu_ready_d = !fifo_full_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            starve_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mdu_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mdu_ready_q <= mdu_ready_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mdu_ready = mdu_ready_q;
    assign dbg_state = state_q;

endmodule
